// File: rtl/z80_bus_pkg.sv
// Shared types and defaults for the z80 bus arbiter: arbitration states,
// bus-owner encoding and default timing constants.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        REQ     = 2'd1,
        DMA_OWN = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int DEF_MIN_CPU_CYCLES = 4;
    localparam int DEF_MAX_HOLD       = 64;

endpackage

// File: rtl/z80_bus_hold_timer.sv
// Loadable up-counter that saturates at LIMIT and flags when it sits there.
// Clear has priority over load, load over counting.
module z80_bus_hold_timer #(
    parameter int WIDTH     = 8,
    parameter int LIMIT     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_reg, count_next;

    always_comb begin
        count_next = count_reg;
        if (clr)
            count_next = '0;
        else if (load)
            count_next = load_val;
        else if (en && (count_reg != LIMIT_V))
            count_next = count_reg + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            count_reg <= WIDTH'(RESET_VAL);
        else
            count_reg <= count_next;
    end

    assign tc = (count_reg == LIMIT_V);

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares the memory array between the tv80s core and an external bus master.
// Define ARB_HOLD_TIMEOUT_EN to bound each DMA tenure to MAX_HOLD clocks.
module z80_bus_arbiter
    import z80_bus_pkg::*;
#(
    parameter int MIN_CPU_CYCLES = DEF_MIN_CPU_CYCLES,
    parameter int MAX_HOLD       = DEF_MAX_HOLD
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        cpu_busrq_n,
    input  logic        cpu_busak_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_do,
    input  logic        dma_we,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_di,
    output logic        mem_we,
    output logic [7:0]  dma_tenures,
    output logic        hold_timeout
);

    if (MIN_CPU_CYCLES < 1 || MIN_CPU_CYCLES > 255 || MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_params
        $error("z80_bus_arbiter: MIN_CPU_CYCLES or MAX_HOLD out of range");
    end

    arb_state_t state_reg, state_next;
    owner_t     owner_reg;
    logic [7:0] tenures_reg;
    logic       hold_timeout_reg;
    logic       gap_tc;
    logic       hold_tc;
    logic       timeout_evt;
    logic       enter_dma;
    logic       leave_dma;
    logic       enter_cpu;

    assign enter_dma = (state_reg == REQ)     && (state_next == DMA_OWN);
    assign leave_dma = (state_reg == DMA_OWN) && (state_next == RELEASE);
    assign enter_cpu = (state_reg == RELEASE) && (state_next == CPU_OWN);

    // Gap counter starts saturated so the first request after reset is honoured at once.
    z80_bus_hold_timer #(
        .WIDTH     (8),
        .LIMIT     (MIN_CPU_CYCLES),
        .RESET_VAL (MIN_CPU_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (enter_cpu),
        .load     (1'b0),
        .load_val (8'd0),
        .en       (state_reg == CPU_OWN),
        .tc       (gap_tc)
    );

`ifdef ARB_HOLD_TIMEOUT_EN
    z80_bus_hold_timer #(
        .WIDTH     (16),
        .LIMIT     (MAX_HOLD - 1),
        .RESET_VAL (0)
    ) u_hold_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (enter_dma),
        .load     (1'b0),
        .load_val (16'd0),
        .en       (state_reg == DMA_OWN),
        .tc       (hold_tc)
    );
`else
    assign hold_tc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_reg <= CPU_OWN;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        timeout_evt = 1'b0;
        case (state_reg)
            CPU_OWN: begin
                if (dma_req && gap_tc)
                    state_next = REQ;
            end
            REQ: begin
                // A dropped request wins over an acknowledge arriving the same cycle.
                if (!dma_req)
                    state_next = RELEASE;
                else if (!cpu_busak_n)
                    state_next = DMA_OWN;
            end
            DMA_OWN: begin
                if (!dma_req) begin
                    state_next = RELEASE;
                end else if (hold_tc) begin
                    state_next  = RELEASE;
                    timeout_evt = 1'b1;
                end
            end
            RELEASE: begin
                if (cpu_busak_n)
                    state_next = CPU_OWN;
            end
            default: state_next = CPU_OWN;
        endcase
    end

    always_comb begin
        cpu_busrq_n = 1'b1;
        dma_gnt     = 1'b0;
        case (state_reg)
            REQ:     cpu_busrq_n = 1'b0;
            DMA_OWN: begin
                cpu_busrq_n = 1'b0;
                dma_gnt     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_reg        <= OWN_CPU;
            tenures_reg      <= 8'd0;
            hold_timeout_reg <= 1'b0;
        end else begin
            hold_timeout_reg <= timeout_evt;
            if (enter_dma)
                owner_reg <= OWN_DMA;
            else if (state_next == RELEASE && state_reg != RELEASE)
                owner_reg <= OWN_CPU;
            if (leave_dma)
                tenures_reg <= tenures_reg + 8'd1;
        end
    end

    // Source select follows only the registered owner, so the two masters never overlap.
    always_comb begin
        if (owner_reg == OWN_DMA) begin
            mem_a  = dma_a;
            mem_di = dma_do;
            mem_we = dma_we;
        end else begin
            mem_a  = cpu_a;
            mem_di = cpu_do;
            mem_we = ~cpu_wr_n & ~cpu_mreq_n;
        end
    end

    assign dma_tenures  = tenures_reg;
    assign hold_timeout = hold_timeout_reg;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Randomized bench for z80_bus_arbiter against a transaction-level model of
// the bus handover; honours ARB_HOLD_TIMEOUT_EN when it is defined.
module tb_z80_bus_arbiter;

    localparam int MIN_CPU  = 4;
    localparam int MAX_HOLD = 8;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_busrq_n;
    logic        cpu_busak_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_mreq_n;
    logic        cpu_wr_n;
    logic        dma_req;
    logic        dma_gnt;
    logic [15:0] dma_a;
    logic [7:0]  dma_do;
    logic        dma_we;
    logic [15:0] mem_a;
    logic [7:0]  mem_di;
    logic        mem_we;
    logic [7:0]  dma_tenures;
    logic        hold_timeout;

    always #5 clk = ~clk;

    z80_bus_arbiter #(.MIN_CPU_CYCLES(MIN_CPU), .MAX_HOLD(MAX_HOLD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_busrq_n  (cpu_busrq_n),
        .cpu_busak_n  (cpu_busak_n),
        .cpu_a        (cpu_a),
        .cpu_do       (cpu_do),
        .cpu_mreq_n   (cpu_mreq_n),
        .cpu_wr_n     (cpu_wr_n),
        .dma_req      (dma_req),
        .dma_gnt      (dma_gnt),
        .dma_a        (dma_a),
        .dma_do       (dma_do),
        .dma_we       (dma_we),
        .mem_a        (mem_a),
        .mem_di       (mem_di),
        .mem_we       (mem_we),
        .dma_tenures  (dma_tenures),
        .hold_timeout (hold_timeout)
    );

    logic [7:0] dut_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [15:0] wr_q [$];

    always @(posedge clk) if (mem_we) dut_mem[mem_a] <= mem_di;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Model: who holds the bus, and how long each side has held it.
    bit         m_asking, m_granted, m_draining, m_pulse;
    int         m_cpu_clocks, m_gnt_clocks;
    logic [7:0] m_tenures;
    int         gnt_cycles;

    function automatic void model_reset();
        m_asking     = 1'b0;
        m_granted    = 1'b0;
        m_draining   = 1'b0;
        m_pulse      = 1'b0;
        m_cpu_clocks = MIN_CPU;
        m_gnt_clocks = 0;
        m_tenures    = 8'd0;
    endfunction

    function automatic void model_step();
        m_pulse = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else if (m_granted) begin
            if (!dma_req || (TIMEOUT_ON && m_gnt_clocks == MAX_HOLD)) begin
                m_pulse    = dma_req;
                m_granted  = 1'b0;
                m_draining = 1'b1;
                m_tenures  = m_tenures + 8'd1;
                $display("tenure %0d: %0d clocks%s", m_tenures, m_gnt_clocks, m_pulse ? " (forced release)" : "");
            end else begin
                m_gnt_clocks++;
            end
        end else if (m_asking) begin
            if (!dma_req) begin
                m_asking   = 1'b0;
                m_draining = 1'b1;
            end else if (!cpu_busak_n) begin
                m_asking     = 1'b0;
                m_granted    = 1'b1;
                m_gnt_clocks = 1;
            end
        end else if (m_draining) begin
            if (cpu_busak_n) begin
                m_draining   = 1'b0;
                m_cpu_clocks = 0;
            end
        end else begin
            if (dma_req && m_cpu_clocks >= MIN_CPU) m_asking = 1'b1;
            if (m_cpu_clocks < MIN_CPU) m_cpu_clocks++;
        end
    endfunction

    // Stand-in for the core's bus acknowledge: follows busrq_n after 0..2 extra clocks.
    bit ack_hold = 1'b0;
    int ack_wait = 0;

    task automatic tick();
        logic [15:0] exp_a;
        logic [7:0]  exp_di;
        logic        exp_we;
        if (!reset_n || ack_hold) begin
            cpu_busak_n = 1'b1;
        end else if (cpu_busak_n != cpu_busrq_n) begin
            if (ack_wait == 0) begin
                cpu_busak_n = cpu_busrq_n;
                ack_wait    = $urandom_range(0, 2);
            end else begin
                ack_wait--;
            end
        end
        #1;
        exp_a  = m_granted ? dma_a  : cpu_a;
        exp_di = m_granted ? dma_do : cpu_do;
        exp_we = m_granted ? dma_we : (~cpu_wr_n & ~cpu_mreq_n);
        check("busrq_n",  cpu_busrq_n, !(m_asking || m_granted));
        check("dma_gnt",  dma_gnt,  m_granted);
        check("mem_a",    mem_a,    exp_a);
        check("mem_di",   mem_di,   exp_di);
        check("mem_we",   mem_we,   exp_we);
        check("tenures",  dma_tenures, m_tenures);
        check("hold_to",  hold_timeout, m_pulse);
        if (dma_gnt) gnt_cycles++;
        @(posedge clk);
        if (exp_we) begin
            ref_mem[exp_a] = exp_di;
            wr_q.push_back(exp_a);
        end
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_asking || m_granted || m_draining) && n < 30) begin
            tick();
            n++;
        end
        check("idle_wait", (n < 30), 1'b1);
    endtask

    task automatic cpu_nop(input int pc);
        cpu_a      = 16'(pc);
        cpu_do     = 8'h00;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b1;
    endtask

    initial begin
        int n;
        int pulses;
        int gnt_before;
        logic [7:0] ten_before;

        reset_n = 1'b0; cpu_busak_n = 1'b1;
        cpu_a = 16'h0000; cpu_do = 8'h00; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
        dma_req = 1'b0; dma_a = 16'h0000; dma_do = 8'h00; dma_we = 1'b0;
        gnt_cycles = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held for three clocks
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_busrq", cpu_busrq_n, 1'b1);
        check("rst_gnt",   dma_gnt, 1'b0);
        check("rst_ten",   dma_tenures, 8'h00);
        check("rst_mem_a", mem_a, 16'h0000);

        // Basic grant while the core fetches NOPs
        dma_req = 1'b1;
        n = 0;
        while (!dma_gnt && n < 20) begin cpu_nop(n); tick(); n++; end
        check("grant_wait", dma_gnt, 1'b1);
        dma_a = 16'h3E7F; dma_do = 8'h2A; dma_we = 1'b1;
        tick();
        dma_we = 1'b0; dma_req = 1'b0;
        tick();
        check("gnt_fall", dma_gnt, 1'b0);
        check("ten_one",  dma_tenures, 8'h01);
        wait_idle();
        check("mem_3e7f", dut_mem[16'h3E7F], 8'h2A);
        check("busrq_rel", cpu_busrq_n, 1'b1);

        // Fairness gap right after the bus comes back
        dma_req = 1'b1;
        tick();
        n = 0;
        while (cpu_busrq_n && n < 20) begin n++; tick(); end
        check("fair_gap", n, MIN_CPU);
        dma_req = 1'b0;
        wait_idle();

        // Abort: request dropped in the same cycle the core would acknowledge
        ack_hold = 1'b1;
        gnt_before = gnt_cycles;
        ten_before = dma_tenures;
        dma_req = 1'b1;
        n = 0;
        while (cpu_busrq_n && n < 20) begin tick(); n++; end
        tick();
        dma_req = 1'b0; ack_hold = 1'b0; ack_wait = 0;
        wait_idle();
        check("abort_gnt", gnt_cycles - gnt_before, 0);
        check("abort_ten", dma_tenures, ten_before);
        check("abort_rq",  cpu_busrq_n, 1'b1);

        // No overlap: CPU write just before the grant, DMA aimed at same byte
        cpu_a = 16'h1000; cpu_do = 8'h55; cpu_wr_n = 1'b0; cpu_mreq_n = 1'b0;
        dma_a = 16'h1000; dma_do = 8'hAA; dma_we = 1'b1; dma_req = 1'b1;
        tick();
        cpu_nop(16'h0200);
        n = 0;
        while (!dma_gnt && n < 30) begin tick(); n++; end
        check("ovl_grant", dma_gnt, 1'b1);
        check("ovl_cpu",   dut_mem[16'h1000], 8'h55);
        tick();
        check("ovl_dma",   dut_mem[16'h1000], 8'hAA);
        dma_we = 1'b0; dma_req = 1'b0;
        wait_idle();

        if (TIMEOUT_ON) begin
            // Held request is cut off after MAX_HOLD clocks of grant
            repeat (MIN_CPU) tick();
            ten_before = dma_tenures;
            dma_req = 1'b1;
            n = 0; pulses = 0; gnt_before = gnt_cycles;
            while (n < 60 && !((gnt_cycles - gnt_before) > 0 && !dma_gnt)) begin
                tick();
                n++;
                if (hold_timeout) pulses++;
            end
            check("to_len",   gnt_cycles - gnt_before, MAX_HOLD);
            check("to_pulse", pulses, 1);
            check("to_busrq", cpu_busrq_n, 1'b1);
            check("to_ten",   dma_tenures, ten_before + 8'd1);
            tick();
            check("to_once",  hold_timeout, 1'b0);
            dma_req = 1'b0;
            wait_idle();
        end

        // Randomized traffic with occasional mid-run resets
        begin
            int req_left = 0;
            int idle_left = 3;
            for (int i = 0; i < 3000; i++) begin
                if (dma_req) begin
                    if (req_left == 0) begin
                        dma_req = 1'b0;
                        idle_left = $urandom_range(0, 12);
                    end else begin
                        req_left--;
                    end
                end else if (idle_left == 0) begin
                    dma_req = 1'b1;
                    req_left = $urandom_range(0, 15);
                end else begin
                    idle_left--;
                end
                dma_a      = {8'h10, 8'($urandom)};
                dma_do     = 8'($urandom);
                dma_we     = 1'($urandom);
                cpu_a      = {8'h10, 8'($urandom)};
                cpu_do     = 8'($urandom);
                cpu_mreq_n = 1'($urandom);
                cpu_wr_n   = 1'($urandom);
                reset_n    = ($urandom_range(0, 399) != 0);
                tick();
            end
        end
        reset_n = 1'b1;

        for (int i = 0; i < 40 && i < wr_q.size(); i++)
            check("mem_img", dut_mem[wr_q[wr_q.size() - 1 - i]], ref_mem[wr_q[wr_q.size() - 1 - i]]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
